mb_pattern_generator: RTL and testbench



---
 rtl/mb_pattern_generator.sv | 144 ++++++++++++++
 tb/tb_mb_pattern_generator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mb_pattern_generator.sv
// Receive-side expected-data source for mainband training: a per-lane 23-bit LFSR
// scrambler stream or a static per-lane ID word, advanced only on received beats.
module mb_pattern_generator #(
  parameter int WIDTH = 32,
  parameter int LANES = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [1:0]             i_state,
  input  logic                   i_data_valid,
  input  logic [15:0]            i_burst_len,
  output logic [LANES*WIDTH-1:0] o_gen_data,
  output logic                   o_gen_valid,
  output logic                   o_burst_done,
  output logic [15:0]            o_beat_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_CLEAR   = 2'b01,
    ST_PATTERN = 2'b10,
    ST_LANE_ID = 2'b11
  } mode_e;

  function automatic logic [22:0] lane_seed(input int lane);
    case (lane % 8)
      0:       return 23'h1DBFBC;
      1:       return 23'h0607BB;
      2:       return 23'h1EC760;
      3:       return 23'h18C0DB;
      4:       return 23'h010F12;
      5:       return 23'h19CFC9;
      6:       return 23'h0277CE;
      default: return 23'h1BB807;
    endcase
  endfunction

  mode_e       mode;
  logic        clear;
  logic        beat_ok;
  logic        take_lfsr;
  logic        take_id;
  logic        gen_valid_q, gen_valid_d;
  logic        burst_done_q, burst_done_d;
  logic        done_q, done_d;
  logic [15:0] beat_count_q, beat_count_d;

  assign mode      = mode_e'(i_state);
  assign clear     = (mode == ST_CLEAR);
  // A beat is consumed only in a generating mode and only until the burst has ended.
  assign beat_ok   = i_data_valid && !done_q && (mode == ST_PATTERN || mode == ST_LANE_ID);
  assign take_lfsr = beat_ok && (mode == ST_PATTERN);
  assign take_id   = beat_ok && (mode == ST_LANE_ID);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [22:0] SEED    = lane_seed(gi);
    localparam logic [7:0]  LANE_ID = 8'(gi);

    logic [22:0]      lfsr_q, lfsr_d, lfsr_adv;
    logic [WIDTH-1:0] prbs_word;
    logic [WIDTH-1:0] id_word;
    logic [WIDTH-1:0] data_q, data_d;

    assign id_word = {(WIDTH/16){4'hA, LANE_ID, 4'hA}};

    // Word bit k is the k-th serial output bit, so bit 0 is sent first.
    always_comb begin
      logic [22:0] s;
      s         = lfsr_q;
      prbs_word = '0;
      for (int k = 0; k < WIDTH; k++) begin
        prbs_word[k] = s[22];
        s = {s[21:0], s[22] ^ s[20] ^ s[15] ^ s[7] ^ s[4] ^ s[1]};
      end
      lfsr_adv = s;
    end

    always_comb begin
      lfsr_d = lfsr_q;
      data_d = data_q;
      if (clear) begin
        lfsr_d = SEED;
        data_d = '0;
      end else if (take_lfsr) begin
        lfsr_d = lfsr_adv;
        data_d = prbs_word;
      end else if (take_id) begin
        data_d = id_word;
      end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        lfsr_q <= SEED;
        data_q <= '0;
      end else begin
        lfsr_q <= lfsr_d;
        data_q <= data_d;
      end
    end

    assign o_gen_data[gi*WIDTH +: WIDTH] = data_q;
  end

  always_comb begin
    beat_count_d = beat_count_q;
    done_d       = done_q;
    gen_valid_d  = 1'b0;
    burst_done_d = 1'b0;
    if (clear) begin
      beat_count_d = '0;
      done_d       = 1'b0;
    end else if (beat_ok) begin
      gen_valid_d = 1'b1;
      // Saturating count; the burst ends only on the increment that lands on the length.
      if (beat_count_q != 16'hFFFF) begin
        beat_count_d = beat_count_q + 16'd1;
        if (i_burst_len != 16'd0 && beat_count_d == i_burst_len) begin
          burst_done_d = 1'b1;
          done_d       = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      gen_valid_q  <= 1'b0;
      burst_done_q <= 1'b0;
      done_q       <= 1'b0;
      beat_count_q <= '0;
    end else begin
      gen_valid_q  <= gen_valid_d;
      burst_done_q <= burst_done_d;
      done_q       <= done_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign o_gen_valid  = gen_valid_q;
  assign o_burst_done = burst_done_q;
  assign o_beat_count = beat_count_q;

endmodule

// File: tb/tb_mb_pattern_generator.sv
// Bench for mb_pattern_generator: a beat-level model built from precomputed serial
// scrambler streams, checked every cycle, plus hand-computed literal expectations.
module tb_mb_pattern_generator;
  localparam int W  = 32;
  localparam int L  = 16;
  localparam int NB = 64;

  localparam logic [1:0] S_IDLE = 2'b00, S_CLEAR = 2'b01, S_PAT = 2'b10, S_ID = 2'b11;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     st;
  logic           dv;
  logic [15:0]    bl;
  logic [L*W-1:0] o_gen_data;
  logic           o_gen_valid;
  logic           o_burst_done;
  logic [15:0]    o_beat_count;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] golden [L][NB];
  logic [W-1:0] m_data [L];
  logic         m_valid, m_done_p, m_done;
  logic [15:0]  m_count;
  int           m_pos;

  mb_pattern_generator #(.WIDTH(W), .LANES(L)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_state      (st),
    .i_data_valid (dv),
    .i_burst_len  (bl),
    .o_gen_data   (o_gen_data),
    .o_gen_valid  (o_gen_valid),
    .o_burst_done (o_burst_done),
    .o_beat_count (o_beat_count)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] seed_of(input int lane);
    logic [22:0] tbl [8];
    tbl = '{23'h1DBFBC, 23'h0607BB, 23'h1EC760, 23'h18C0DB,
            23'h010F12, 23'h19CFC9, 23'h0277CE, 23'h1BB807};
    return tbl[lane % 8];
  endfunction

  function automatic logic [W-1:0] id_word(input int lane);
    logic [7:0] id;
    id = 8'(lane);
    return {(W/16){4'hA, id, 4'hA}};
  endfunction

  function automatic logic [W-1:0] lane_out(input int lane);
    return o_gen_data[lane*W +: W];
  endfunction

  // Serial bit stream per lane, then chopped into W-bit words (first bit -> bit 0).
  task automatic build_golden();
    bit stream [NB*W];
    logic [22:0] s;
    for (int l = 0; l < L; l++) begin
      s = seed_of(l);
      for (int n = 0; n < NB*W; n++) begin
        stream[n] = s[22];
        s = {s[21:0], s[22] ^ s[20] ^ s[15] ^ s[7] ^ s[4] ^ s[1]};
      end
      for (int b = 0; b < NB; b++)
        for (int k = 0; k < W; k++)
          golden[l][b][k] = stream[b*W + k];
    end
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < L; l++) m_data[l] = '0;
    m_valid = 0; m_done_p = 0; m_done = 0; m_count = 0; m_pos = 0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_valid  = 0;
    m_done_p = 0;
    if (st == S_CLEAR) begin
      for (int l = 0; l < L; l++) m_data[l] = '0;
      m_pos = 0; m_count = 0; m_done = 0;
    end else if ((st == S_PAT || st == S_ID) && dv && !m_done) begin
      for (int l = 0; l < L; l++)
        m_data[l] = (st == S_PAT) ? golden[l][m_pos] : id_word(l);
      if (st == S_PAT) m_pos++;
      m_valid = 1;
      if (m_count < 16'hFFFF) begin
        m_count++;
        if (bl != 0 && m_count == bl) begin
          m_done_p = 1;
          m_done   = 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("gen_valid", {31'd0, o_gen_valid}, {31'd0, m_valid});
    chk("burst_done", {31'd0, o_burst_done}, {31'd0, m_done_p});
    chk("beat_count", {16'd0, o_beat_count}, {16'd0, m_count});
    for (int l = 0; l < L; l++)
      chk($sformatf("data_lane%0d", l), lane_out(l), m_data[l]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic [1:0] s, input logic v, input int n);
    st = s;
    dv = v;
    repeat (n) tick();
  endtask

  initial begin
    int nv;
    int done_at;
    rst_n = 1'b0; st = S_IDLE; dv = 1'b0; bl = 16'd0;
    build_golden();
    model_reset();
    #2;
    repeat (2) tick();
    chk("reset_count", {16'd0, o_beat_count}, 32'd0);
    chk("reset_valid", {31'd0, o_gen_valid}, 32'd0);
    rst_n = 1'b1;

    // First beat: lane 0 starts with the bit-reversed seed.
    drive(S_CLEAR, 0, 1);
    drive(S_PAT, 1, 1);
    chk("first_valid", {31'd0, o_gen_valid}, 32'd1);
    chk("lane0_seed_rev", {9'd0, lane_out(0)[22:0]}, 32'h001EFEDC);
    chk("lane8_eq_lane0", lane_out(8), lane_out(0));
    chk("lane1_ne_lane0", {31'd0, lane_out(1) != lane_out(0)}, 32'd1);
    drive(S_PAT, 0, 1);
    chk("valid_one_cycle", {31'd0, o_gen_valid}, 32'd0);

    // Burst of 4 with 6 offered beats.
    drive(S_CLEAR, 0, 1);
    bl = 16'd4; st = S_PAT; dv = 1'b1;
    nv = 0; done_at = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      nv += int'(o_gen_valid);
      if (o_burst_done) done_at = i;
    end
    chk("burst_valid_beats", nv, 32'd4);
    chk("burst_done_beat", done_at, 32'd4);
    chk("burst_count", {16'd0, o_beat_count}, 32'd4);

    // IDLE gap must not disturb the stream.
    drive(S_CLEAR, 0, 1);
    bl = 16'd0;
    drive(S_PAT, 1, 3);
    drive(S_IDLE, 1, 5);
    drive(S_PAT, 1, 1);
    chk("after_idle_word3", lane_out(0), golden[0][3]);

    // Per-lane ID words.
    drive(S_CLEAR, 0, 1);
    drive(S_ID, 1, 1);
    chk("id_lane5", lane_out(5), 32'hA05AA05A);
    chk("id_lane15", lane_out(15), 32'hA0FAA0FA);

    // LFSR resumes across an ID interlude.
    drive(S_CLEAR, 0, 1);
    drive(S_PAT, 1, 2);
    drive(S_ID, 1, 1);
    drive(S_PAT, 1, 1);
    chk("resume_word2", lane_out(3), golden[3][2]);

    // CLEAR wins over a same-cycle valid.
    drive(S_CLEAR, 0, 1);
    bl = 16'd10;
    drive(S_PAT, 1, 3);
    drive(S_CLEAR, 1, 1);
    chk("clear_count", {16'd0, o_beat_count}, 32'd0);
    chk("clear_data", lane_out(0), 32'd0);
    chk("clear_valid", {31'd0, o_gen_valid}, 32'd0);
    drive(S_PAT, 1, 1);
    chk("clear_restart", lane_out(0), golden[0][0]);

    // Burst length lowered below the count: no done pulse, counting continues.
    drive(S_CLEAR, 0, 1);
    bl = 16'd8;
    drive(S_PAT, 1, 5);
    bl = 16'd3;
    drive(S_PAT, 1, 4);
    chk("lowered_len_count", {16'd0, o_beat_count}, 32'd9);

    // Asynchronous reset between edges mid-burst.
    drive(S_CLEAR, 0, 1);
    bl = 16'd0;
    drive(S_PAT, 1, 2);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_count", {16'd0, o_beat_count}, 32'd0);
    chk("async_valid", {31'd0, o_gen_valid}, 32'd0);
    chk("async_data", lane_out(0), 32'd0);
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    st = S_CLEAR; dv = 1'b0;
    rst_n = 1'b1;
    tick();
    drive(S_PAT, 1, 1);
    chk("async_restart_l0", lane_out(0), golden[0][0]);
    chk("async_restart_l9", lane_out(9), golden[9][0]);
    drive(S_IDLE, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
